alu_sequencer: RTL

Byte-serial front end and result register stage for the 8-bit `ALU`. It collects a command byte and operand bytes over a valid/ready input stream, then drives the combinational ALU for one cycle. It captures `RESULT` and the four flags into an accumulator/status register and presents them on a valid/ready output stream. It sits between the pad-level byte interface and the `ALU` instance, both upstream (operands) and downstream (result capture) of it.

---
 rtl/alu_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Byte-serial command/operand collector and result register stage for the 8-bit ALU.
// Optional idle-timeout abort is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_s_amt,
    output logic [2:0] alu_ctrl,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [7:0] out_result,
    output logic [3:0] out_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        ST_CMD  = 3'd0,
        ST_LD_A = 3'd1,
        ST_LD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_nx_s;
    logic       in_ready_r;
    logic       out_valid_r;
    logic       in_ready_nx_s;
    logic       out_valid_nx_s;
    logic       accept_s;
    logic       abort_s;
    logic       frame_err_r;
    logic [7:0] alu_a_r;
    logic [7:0] alu_b_r;
    logic [3:0] alu_s_amt_r;
    logic [2:0] alu_ctrl_r;
    logic [7:0] out_result_r;
    logic [3:0] out_flags_r;

    assign accept_s = in_valid & in_ready_r;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] idle_cnt_r;
    logic       in_load_s;

    assign in_load_s = (state_r == ST_LD_A) || (state_r == ST_LD_B);
    assign abort_s   = in_load_s && !accept_s && (idle_cnt_r == TIMEOUT_LAST);

    // Idle counter: counts stalled cycles inside a frame, cleared by every accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= 8'd0;
        end else if (accept_s || !in_load_s) begin
            idle_cnt_r <= 8'd0;
        end else begin
            idle_cnt_r <= idle_cnt_r + 8'd1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign abort_s = 1'b0;
`endif

    // State register plus the registered handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CMD;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            frame_err_r <= abort_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_CMD: begin
                if (accept_s) begin
                    state_nx_s = in_data[7] ? ST_LD_B : ST_LD_A;
                end else begin
                    state_nx_s = ST_CMD;
                end
            end
            ST_LD_A: begin
                if (abort_s) begin
                    state_nx_s = ST_CMD;
                end else if (accept_s) begin
                    state_nx_s = ST_LD_B;
                end else begin
                    state_nx_s = ST_LD_A;
                end
            end
            ST_LD_B: begin
                if (abort_s) begin
                    state_nx_s = ST_CMD;
                end else if (accept_s) begin
                    state_nx_s = ST_EXEC;
                end else begin
                    state_nx_s = ST_LD_B;
                end
            end
            ST_EXEC: state_nx_s = ST_RESP;
            ST_RESP: begin
                if (out_valid_r && out_ready) begin
                    state_nx_s = ST_CMD;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: state_nx_s = ST_CMD;
        endcase
    end

    // Output decode of the next state, registered alongside the state.
    always_comb begin
        in_ready_nx_s  = 1'b0;
        out_valid_nx_s = 1'b0;
        case (state_nx_s)
            ST_CMD, ST_LD_A, ST_LD_B: in_ready_nx_s = 1'b1;
            ST_RESP:                  out_valid_nx_s = 1'b1;
            default: begin
                in_ready_nx_s  = 1'b0;
                out_valid_nx_s = 1'b0;
            end
        endcase
    end

    // Operand, control and accumulator registers; the accumulator only changes in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r      <= 8'd0;
            alu_b_r      <= 8'd0;
            alu_s_amt_r  <= 4'd0;
            alu_ctrl_r   <= 3'd0;
            out_result_r <= 8'd0;
            out_flags_r  <= 4'd0;
        end else begin
            if ((state_r == ST_CMD) && accept_s) begin
                alu_ctrl_r  <= in_data[2:0];
                alu_s_amt_r <= in_data[6:3];
                if (in_data[7]) begin
                    alu_a_r <= out_result_r;
                end
            end
            if ((state_r == ST_LD_A) && accept_s) begin
                alu_a_r <= in_data;
            end
            if ((state_r == ST_LD_B) && accept_s) begin
                alu_b_r <= in_data;
            end
            if (state_r == ST_EXEC) begin
                out_result_r <= alu_result;
                out_flags_r  <= alu_flags;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign frame_err  = frame_err_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_s_amt  = alu_s_amt_r;
    assign alu_ctrl   = alu_ctrl_r;
    assign out_result = out_result_r;
    assign out_flags  = out_flags_r;

endmodule
